// File: rtl/pll_dyn_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_dyn_cfg_ctrl
// Purpose  : rPLL dynamic-divider sequencer: reset pulsing, lock qualification
//            with timeout/retry, and valid/ready divider-code reconfiguration.
// Revision : 1.0 - initial release
// ============================================================================
module pll_dyn_cfg_ctrl #(
  parameter int          RESET_CYCLES  = 16,
  parameter int          LOCK_TIMEOUT  = 65535,
  parameter int          STABLE_CYCLES = 1024,
  parameter int          MAX_RETRY     = 3,
  parameter logic [5:0]  DEF_IDSEL     = 6'd62,
  parameter logic [5:0]  DEF_FBDSEL    = 6'd53,
  parameter logic [5:0]  DEF_ODSEL     = 6'd56
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cfg_valid,
  output logic       o_cfg_ready,
  input  logic [5:0] i_cfg_idsel,
  input  logic [5:0] i_cfg_fbdsel,
  input  logic [5:0] i_cfg_odsel,
  input  logic       i_pll_lock,
  output logic       o_pll_reset,
  output logic [5:0] o_pll_idsel,
  output logic [5:0] o_pll_fbdsel,
  output logic [5:0] o_pll_odsel,
  output logic       o_locked,
  output logic       o_lock_lost,
  output logic       o_error,
  output logic [1:0] o_retry_cnt
);

  localparam int c_CNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT) ?
                             ((RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES) :
                             ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RESET_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT  = {c_CNT_W{1'b1}};
  localparam logic [1:0]         c_MAX_RETRY = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST_HOLD  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_LOCKED    = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t               r_state,  w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt,  w_cnt_inc;
  logic [1:0]           r_retry,  w_retry_nxt;
  logic [5:0]           r_idsel,  w_idsel_nxt;
  logic [5:0]           r_fbdsel, w_fbdsel_nxt;
  logic [5:0]           r_odsel,  w_odsel_nxt;
  logic                 r_lock_lost, w_lock_lost_nxt;
  logic                 r_pll_reset, r_cfg_ready, r_locked, r_error;
  logic                 r_lock_m, r_lock_s;
  logic                 w_hs;

  assign w_hs      = i_cfg_valid & r_cfg_ready;
  assign w_cnt_inc = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + c_CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_inc;
    w_retry_nxt     = r_retry;
    w_idsel_nxt     = r_idsel;
    w_fbdsel_nxt    = r_fbdsel;
    w_odsel_nxt     = r_odsel;
    w_lock_lost_nxt = 1'b0;
    case (r_state)
      S_RST_HOLD: begin
        if (r_cnt == c_RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_TO_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry < c_MAX_RETRY) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = S_RST_HOLD;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (!r_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_STB_LAST) begin
          w_state_nxt = S_LOCKED;
          w_cnt_nxt   = '0;
          w_retry_nxt = 2'd0;
        end
      end
      S_LOCKED: begin
        w_cnt_nxt       = r_cnt;
        w_lock_lost_nxt = ~r_lock_s;
        // A handshake and a lock loss on the same edge both land in RST_HOLD;
        // only the handshake changes the codes.
        if (w_hs || !r_lock_s) begin
          w_state_nxt = S_RST_HOLD;
          w_cnt_nxt   = '0;
        end
        if (w_hs) begin
          w_idsel_nxt  = i_cfg_idsel;
          w_fbdsel_nxt = i_cfg_fbdsel;
          w_odsel_nxt  = i_cfg_odsel;
        end
      end
      S_FAIL: begin
        w_cnt_nxt = r_cnt;
        if (w_hs) begin
          w_state_nxt  = S_RST_HOLD;
          w_cnt_nxt    = '0;
          w_retry_nxt  = 2'd0;
          w_idsel_nxt  = i_cfg_idsel;
          w_fbdsel_nxt = i_cfg_fbdsel;
          w_odsel_nxt  = i_cfg_odsel;
        end
      end
      default: begin
        w_state_nxt = S_RST_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RST_HOLD;
      r_cnt       <= '0;
      r_retry     <= 2'd0;
      r_idsel     <= DEF_IDSEL;
      r_fbdsel    <= DEF_FBDSEL;
      r_odsel     <= DEF_ODSEL;
      r_pll_reset <= 1'b1;
      r_cfg_ready <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_error     <= 1'b0;
      r_lock_m    <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_idsel     <= w_idsel_nxt;
      r_fbdsel    <= w_fbdsel_nxt;
      r_odsel     <= w_odsel_nxt;
      // Codes only move on transitions into RST_HOLD, so the PLL never sees
      // a divider change while out of reset.
      r_pll_reset <= (w_state_nxt == S_RST_HOLD) || (w_state_nxt == S_FAIL);
      r_cfg_ready <= (w_state_nxt == S_LOCKED)   || (w_state_nxt == S_FAIL);
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_error     <= (w_state_nxt == S_FAIL);
      r_lock_lost <= w_lock_lost_nxt;
      r_lock_m    <= i_pll_lock;
      r_lock_s    <= r_lock_m;
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_pll_reset  = r_pll_reset;
  assign o_pll_idsel  = r_idsel;
  assign o_pll_fbdsel = r_fbdsel;
  assign o_pll_odsel  = r_odsel;
  assign o_locked     = r_locked;
  assign o_lock_lost  = r_lock_lost;
  assign o_error      = r_error;
  assign o_retry_cnt  = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_dyn_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_dyn_cfg_ctrl
// Purpose  : Directed self-checking bench for pll_dyn_cfg_ctrl (small timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_dyn_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [5:0] i_cfg_idsel, i_cfg_fbdsel, i_cfg_odsel;
  logic       i_pll_lock;
  logic       o_pll_reset;
  logic [5:0] o_pll_idsel, o_pll_fbdsel, o_pll_odsel;
  logic       o_locked, o_lock_lost, o_error;
  logic [1:0] o_retry_cnt;

  int checks   = 0;
  int failures = 0;

  pll_dyn_cfg_ctrl #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_idsel (i_cfg_idsel),
    .i_cfg_fbdsel(i_cfg_fbdsel),
    .i_cfg_odsel (i_cfg_odsel),
    .i_pll_lock  (i_pll_lock),
    .o_pll_reset (o_pll_reset),
    .o_pll_idsel (o_pll_idsel),
    .o_pll_fbdsel(o_pll_fbdsel),
    .o_pll_odsel (o_pll_odsel),
    .o_locked    (o_locked),
    .o_lock_lost (o_lock_lost),
    .o_error     (o_error),
    .o_retry_cnt (o_retry_cnt)
  );

  always #5 clk = ~clk;

  logic [17:0] w_codes;
  assign w_codes = {o_pll_idsel, o_pll_fbdsel, o_pll_odsel};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_until_locked(input int max, output int n, output bit lost);
    n    = -1;
    lost = 1'b0;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (o_lock_lost) lost = 1'b1;
      if (o_locked) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, o_pll_reset, 1);
    chk({tag, "_codes"},     w_codes, {6'd62, 6'd53, 6'd56});
    chk({tag, "_ready"},     o_cfg_ready, 0);
    chk({tag, "_locked"},    o_locked, 0);
    chk({tag, "_lost"},      o_lock_lost, 0);
    chk({tag, "_error"},     o_error, 0);
    chk({tag, "_retry"},     o_retry_cnt, 0);
  endtask

  // Codes may only change on an edge where pll_reset is (or goes) high.
  bit          mon_en = 1'b0;
  logic [17:0] prev_codes;
  always @(posedge clk) begin
    #1;
    if (mon_en && (w_codes !== prev_codes)) begin
      checks++;
      assert (o_pll_reset === 1'b1) else begin
        failures++;
        $error("FAIL code_change_out_of_reset observed=%0h expected=1", o_pll_reset);
      end
    end
    prev_codes = w_codes;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit lost;
    int rises;
    logic prev_rst;
    logic [1:0] ra [1:3];

    rst_n        = 1'b0;
    i_cfg_valid  = 1'b0;
    i_cfg_idsel  = 6'd0;
    i_cfg_fbdsel = 6'd0;
    i_cfg_odsel  = 6'd0;
    i_pll_lock   = 1'b1;
    ra[1] = 2'd0; ra[2] = 2'd0; ra[3] = 2'd0;

    // Power-up with lock present from the start
    repeat (3) cyc();
    chk_reset_vals("por");
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (3) cyc();
    chk("por_hold_e3", o_pll_reset, 1);
    cyc();
    chk("por_release_e4", o_pll_reset, 0);
    run_until_locked(50, n, lost);
    chk("por_lock_latency", n, 9);
    chk("por_codes", w_codes, {6'd62, 6'd53, 6'd56});
    chk("por_ready", o_cfg_ready, 1);
    chk("por_error", o_error, 0);

    // Reconfigure while locked
    i_cfg_valid = 1'b1; i_cfg_idsel = 6'd60; i_cfg_fbdsel = 6'd40; i_cfg_odsel = 6'd58;
    cyc();
    i_cfg_valid = 1'b0;
    chk("cfg_ready_drop", o_cfg_ready, 0);
    chk("cfg_pll_reset", o_pll_reset, 1);
    chk("cfg_codes", w_codes, {6'd60, 6'd40, 6'd58});
    chk("cfg_locked", o_locked, 0);
    chk("cfg_lost", o_lock_lost, 0);
    run_until_locked(50, n, lost);
    chk("cfg_relock_latency", n, 13);
    chk("cfg_no_lost", lost, 0);

    // Lock loss while LOCKED, then a 1-cycle glitch during STABLE
    i_pll_lock = 1'b0;
    cyc();
    cyc();
    chk("loss_still_locked", o_locked, 1);
    cyc();
    chk("loss_pulse", o_lock_lost, 1);
    chk("loss_locked", o_locked, 0);
    chk("loss_pll_reset", o_pll_reset, 1);
    chk("loss_codes", w_codes, {6'd60, 6'd40, 6'd58});
    i_pll_lock = 1'b1;
    cyc();
    chk("loss_pulse_end", o_lock_lost, 0);
    repeat (3) cyc();
    chk("loss_release", o_pll_reset, 0);
    cyc();
    i_pll_lock = 1'b0;
    cyc();
    i_pll_lock = 1'b1;
    run_until_locked(60, n, lost);
    chk("glitch_relock_latency", n, 11);
    chk("glitch_retry", o_retry_cnt, 0);
    chk("glitch_no_lost", lost, 0);

    // Handshake on the same edge as a lock loss
    i_pll_lock = 1'b0;
    cyc();
    cyc();
    chk("sim_pre_locked", o_locked, 1);
    i_cfg_valid = 1'b1; i_cfg_idsel = 6'd1; i_cfg_fbdsel = 6'd2; i_cfg_odsel = 6'd3;
    cyc();
    i_cfg_valid = 1'b0;
    chk("sim_lost", o_lock_lost, 1);
    chk("sim_codes", w_codes, {6'd1, 6'd2, 6'd3});
    chk("sim_pll_reset", o_pll_reset, 1);
    chk("sim_ready", o_cfg_ready, 0);
    repeat (6) cyc();
    chk("mid_wait_pll_reset", o_pll_reset, 0);

    // Reset asserted mid-WAIT_LOCK
    rst_n = 1'b0;
    cyc();
    chk_reset_vals("midrst");
    cyc();

    // No lock at all: retries then FAIL; cfg_valid must be ignored meanwhile
    i_cfg_valid = 1'b1; i_cfg_idsel = 6'd7; i_cfg_fbdsel = 6'd7; i_cfg_odsel = 6'd7;
    rst_n    = 1'b1;
    rises    = 0;
    prev_rst = o_pll_reset;
    n        = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (o_error) begin
        n = i;
        break;
      end
      if (o_pll_reset && !prev_rst) begin
        rises++;
        if (rises <= 3) ra[rises] = o_retry_cnt;
      end
      prev_rst = o_pll_reset;
    end
    i_cfg_valid = 1'b0;
    chk("fail_edge", n, 72);
    chk("fail_retry_pulses", rises, 2);
    chk("fail_retry_at_1", ra[1], 1);
    chk("fail_retry_at_2", ra[2], 2);
    chk("fail_retry_cnt", o_retry_cnt, 2);
    chk("fail_ready", o_cfg_ready, 1);
    chk("fail_codes_ignored", w_codes, {6'd62, 6'd53, 6'd56});
    repeat (5) cyc();
    chk("fail_pll_reset_stuck", o_pll_reset, 1);
    chk("fail_error_stuck", o_error, 1);

    // Recovery from FAIL through a handshake
    i_cfg_valid = 1'b1; i_cfg_idsel = 6'd10; i_cfg_fbdsel = 6'd20; i_cfg_odsel = 6'd30;
    cyc();
    i_cfg_valid = 1'b0;
    i_pll_lock  = 1'b1;
    chk("rec_error", o_error, 0);
    chk("rec_retry", o_retry_cnt, 0);
    chk("rec_ready", o_cfg_ready, 0);
    chk("rec_pll_reset", o_pll_reset, 1);
    chk("rec_codes", w_codes, {6'd10, 6'd20, 6'd30});
    run_until_locked(60, n, lost);
    chk("rec_relock_latency", n, 13);
    chk("rec_error_after", o_error, 0);
    chk("rec_retry_after", o_retry_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_dyn_cfg_ctrl.md
Name: pll_dyn_cfg_ctrl

Overview:
Sequences a Gowin rPLL instance running in dynamic-divider mode (DYN_IDIV/FBDIV/ODIV_SEL enabled).
- Drives the PLL RESET and IDSEL/FBDSEL/ODSEL code inputs.
- Waits for LOCK and qualifies it as stable, with timeout and bounded retry.
- Accepts runtime reconfiguration requests over a valid/ready handshake.
- Runs on the free-running board clock (27 MHz), never on a PLL output. Its locked output gates reset release for logic in the PLL output domain (video/LCD timing).

Parameters:
RESET_CYCLES, 16, cycles pll_reset is held high per reset pulse (min 1)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before a retry
STABLE_CYCLES, 1024, consecutive synced-lock cycles needed to declare lock
MAX_RETRY, 3, timeout retries before FAIL
DEF_IDSEL, 6'd62, power-on IDSEL code; raw code, passed verbatim
DEF_FBDSEL, 6'd53, power-on FBDSEL code
DEF_ODSEL, 6'd56, power-on ODSEL code

Ports:
clk  in  1  free-running board clock
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
cfg_idsel  in  6  requested IDSEL code
cfg_fbdsel  in  6  requested FBDSEL code
cfg_odsel  in  6  requested ODSEL code
pll_lock  in  1  rPLL LOCK, asynchronous
pll_reset  out  1  to rPLL RESET
pll_idsel  out  6  to rPLL IDSEL
pll_fbdsel  out  6  to rPLL FBDSEL
pll_odsel  out  6  to rPLL ODSEL
locked  out  1  qualified stable lock
lock_lost  out  1  one-cycle pulse on unrequested lock loss
error  out  1  retries exhausted
retry_cnt  out  2  timeouts since last good lock

Behaviour:
General
- Clock, reset and signalling: one clock; reset is synchronous and active-low. All outputs are registered. pll_lock passes through a 2-FF synchronizer (lock_s), adding 2 cycles of latency.
- Reset: while rst_n=0 at posedge, all of the following hold:
  - state=RST_HOLD, pll_reset=1.
  - pll_*sel = DEF_* codes.
  - cfg_ready=0, locked=0, lock_lost=0, error=0, retry_cnt=0, counter=0.
  - Synchronizer cleared.
- Invariant: pll_*sel change only on the same edge that pll_reset goes or stays 1. The codes are never altered while the PLL is out of reset.

States
- RST_HOLD: pll_reset=1; count RESET_CYCLES cycles, then go to WAIT_LOCK with counter cleared.
- WAIT_LOCK: pll_reset=0.
  - lock_s=1 -> STABLE, counter cleared.
  - counter==LOCK_TIMEOUT-1 with retry_cnt<MAX_RETRY -> retry_cnt+1, go to RST_HOLD.
  - counter==LOCK_TIMEOUT-1 with retry_cnt==MAX_RETRY -> FAIL.
- STABLE: count consecutive lock_s=1 cycles.
  - Any lock_s=0 -> WAIT_LOCK; the timeout counter restarts and retry_cnt is unchanged.
  - STABLE_CYCLES reached -> LOCKED; locked=1, retry_cnt=0.
- LOCKED: cfg_ready=1.
  - Handshake: capture cfg_* into pll_*sel, pll_reset=1, locked=0, go to RST_HOLD.
  - lock_s=0 without a handshake: lock_lost pulses for 1 cycle, locked=0, go to RST_HOLD with the codes unchanged.
  - Simultaneous handshake and lock loss: the handshake wins (new codes captured) and lock_lost still pulses.
- FAIL: error=1, pll_reset=1, cfg_ready=1. A handshake captures new codes, clears error and retry_cnt, and goes to RST_HOLD.

cfg_ready and cfg_valid
- cfg_ready=0 in RST_HOLD, WAIT_LOCK and STABLE. cfg_valid there is ignored, not queued.
- cfg_ready drops the cycle after acceptance.

Counters
- Counter width is $clog2(max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1).
- The counter saturates and never wraps.
- retry_cnt width is fixed at 2 bits, so MAX_RETRY must be ≤3.

Mid-operation reset
- rst_n low in any state returns to the reset values within one edge. Codes revert to DEF_*.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- Power-up with pll_lock=1 from cycle 0 -> pll_reset high for the 4 cycles after rst_n release; codes stay at 62/53/56; locked rises exactly 2+8 cycles after entering WAIT_LOCK (±1 documented edge); error=0.
- pll_lock held 0 -> exactly 3 reset pulses (initial plus 2 retries); retry_cnt steps 0→1→2; then error=1 and pll_reset stuck at 1.
- While locked, send cfg 60/40/58 -> cfg_ready drops next cycle; pll_reset=1 on the same edge the codes change; locked=0 until relock; no lock_lost pulse.
- Lock glitch low for 1 cycle during STABLE -> no locked; stable count restarts; locked rises 8 cycles after lock_s returns high.
- Lock drop while LOCKED -> lock_lost pulses exactly 1 cycle; codes unchanged; relock sequence repeats; retry_cnt=0 on success.
- In FAIL, send cfg then release lock -> error clears on the handshake edge; relock succeeds. Separately, assert rst_n=0 mid-WAIT_LOCK -> every output returns to its reset value on the next edge.
